// File: rtl/adder_tree_seq.sv
// adder_tree_seq: accumulates the signed sum of all lanes across a job of
// num_chunks chunks. Each accepted chunk is reduced by a pairwise adder tree
// and added to a wide accumulator; the total is offered with a valid/ready
// handshake once the last chunk has been absorbed.
module adder_tree_seq #(
  parameter int INPUT_BW   = 8,
  parameter int LAYER_NUM  = 3,
  parameter int ARRAY_SIZE = 8,
  parameter int CNT_BW     = 8,
  parameter int ACC_BW     = 19
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [CNT_BW-1:0]                    num_chunks,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0]  operands,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [ACC_BW-1:0]             result,
  output logic                                 busy
);

  localparam int SUM_BW = INPUT_BW + LAYER_NUM;

  // Parameter consistency: the tree must consume exactly ARRAY_SIZE lanes and
  // the accumulator must be wide enough for the largest legal job.
  if (ARRAY_SIZE != (1 << LAYER_NUM)) begin : g_bad_array_size
    $error("adder_tree_seq: ARRAY_SIZE must equal 2**LAYER_NUM");
  end
  if (ACC_BW != INPUT_BW + LAYER_NUM + CNT_BW) begin : g_bad_acc_bw
    $error("adder_tree_seq: ACC_BW must equal INPUT_BW+LAYER_NUM+CNT_BW");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic signed [ACC_BW-1:0]   r_acc;
  logic        [CNT_BW-1:0]   r_rem;
  logic                       w_accept;
  logic signed [SUM_BW-1:0]   w_tree_sum;
  logic signed [ACC_BW-1:0]   w_sum_ext;

  // Pairwise reduction tree: layer l holds ARRAY_SIZE>>l nodes, each one bit
  // wider than the layer below so no partial sum can overflow.
  for (genvar l = 0; l <= LAYER_NUM; l++) begin : g_lvl
    localparam int NW = INPUT_BW + l;
    localparam int NN = ARRAY_SIZE >> l;
    logic signed [NW-1:0] w_node [NN];
    if (l == 0) begin : g_leaf
      for (genvar n = 0; n < NN; n++) begin : g_n
        assign w_node[n] = operands[n];
      end
    end else begin : g_sum
      for (genvar n = 0; n < NN; n++) begin : g_n
        assign w_node[n] = {g_lvl[l-1].w_node[2*n][NW-2],   g_lvl[l-1].w_node[2*n]}
                         + {g_lvl[l-1].w_node[2*n+1][NW-2], g_lvl[l-1].w_node[2*n+1]};
      end
    end
  end

  assign w_tree_sum = g_lvl[LAYER_NUM].w_node[0];
  assign w_sum_ext  = {{(ACC_BW-SUM_BW){w_tree_sum[SUM_BW-1]}}, w_tree_sum};
  assign w_accept   = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_chunks == '0) w_next = S_DONE;
          else                  w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept && (r_rem == CNT_BW'(1))) w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; all handshake outputs are pure functions of the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator and remaining-chunk counter: cleared on a job start, updated
  // on each accepted chunk, otherwise held (keeps result stable in DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rem <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_acc <= '0;
        r_rem <= num_chunks;
      end
    end else if (w_accept) begin
      r_acc <= r_acc + w_sum_ext;
      r_rem <= r_rem - CNT_BW'(1);
    end
  end

  assign result = r_acc;

endmodule

// File: tb/tb_adder_tree_seq.sv
// Testbench for adder_tree_seq: directed table of jobs with fixed expected
// totals, hand-written reset/start corner sequences, and random jobs checked
// against a plain-arithmetic lane-sum model.
module tb_adder_tree_seq;

  localparam int INPUT_BW   = 8;
  localparam int LAYER_NUM  = 3;
  localparam int ARRAY_SIZE = 8;
  localparam int CNT_BW     = 8;
  localparam int ACC_BW     = 19;

  logic                                clk;
  logic                                rst_n;
  logic                                start;
  logic [CNT_BW-1:0]                   num_chunks;
  logic                                in_valid;
  logic                                in_ready;
  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0] operands;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [ACC_BW-1:0]            result;
  logic                                busy;

  adder_tree_seq #(
    .INPUT_BW  (INPUT_BW),
    .LAYER_NUM (LAYER_NUM),
    .ARRAY_SIZE(ARRAY_SIZE),
    .CNT_BW    (CNT_BW),
    .ACC_BW    (ACC_BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_chunks(num_chunks),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operands  (operands),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [ARRAY_SIZE-1:0][INPUT_BW-1:0] chunk_t;
  chunk_t chunk_q[$];

  typedef struct {
    int          nc;
    int          base;
    int          cstep;
    bit          ramp;
    int          vmode;
    logic [15:0] vpat;
    int          hold;
    bit          glitch;
    int          exp_res;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Reference: total of all lanes of all queued chunks, as signed integers.
  function automatic longint model_sum();
    longint s = 0;
    foreach (chunk_q[c])
      for (int i = 0; i < ARRAY_SIZE; i++)
        s += longint'($signed(chunk_q[c][i]));
    return s;
  endfunction

  // vmode: 0 = always valid, 1 = vpat bit per cycle, 2 = random.
  task automatic run_job(input int nc, input longint exp_res, input int vmode,
                         input logic [15:0] vpat, input int hold, input bit glitch);
    int acc = 0;
    int cyc = 0;
    bit v;
    bit took;
    chk("idle_before_start", busy, 0);
    start = 1'b1;
    num_chunks = CNT_BW'(nc);
    @(posedge clk); #1;
    start = 1'b0;
    num_chunks = '0;
    if (nc > 0) begin
      chk("in_ready_after_start", in_ready, 1);
      chk("busy_after_start", busy, 1);
    end
    while (acc < nc && cyc < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc < 16) ? vpat[cyc] : 1'b1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      operands = chunk_q[acc];
      if (glitch && acc == 1) begin
        start = 1'b1;
        num_chunks = CNT_BW'(9);
      end else begin
        start = 1'b0;
      end
      took = v && in_ready;
      @(posedge clk); #1;
      if (took) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (acc < nc) chk("chunk_accept_timeout", acc, nc);
    chk("out_valid_after_last", out_valid, 1);
    chk("in_ready_after_last", in_ready, 0);
    chk("result", result, exp_res);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (glitch && h == 0) begin
        start = 1'b1;
        num_chunks = CNT_BW'(9);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, exp_res);
    end
    out_ready = 1'b1;
    if (glitch) begin
      start = 1'b1;
      num_chunks = CNT_BW'(9);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    chk("out_valid_after_handshake", out_valid, 0);
    chk("busy_after_handshake", busy, 0);
    @(posedge clk); #1;
    chk("stays_idle", busy, 0);
  endtask

  initial begin
    chunk_t ch;
    longint expv;
    int nc;

    tbl[0] = '{2,    1, 1, 1'b0, 0, 16'h0000, 0, 1'b0,    24};
    tbl[1] = '{3, -128, 0, 1'b0, 0, 16'h0000, 1, 1'b0, -3072};
    tbl[2] = '{1,  127, 0, 1'b0, 0, 16'h0000, 0, 1'b0,  1016};
    tbl[3] = '{0,    0, 0, 1'b0, 0, 16'h0000, 5, 1'b0,     0};
    tbl[4] = '{4,    0, 0, 1'b1, 1, 16'h0059, 2, 1'b0,   112};
    tbl[5] = '{3,    2, 1, 1'b0, 0, 16'h0000, 1, 1'b1,    72};

    rst_n = 1'b0;
    start = 1'b0;
    num_chunks = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    operands = '0;
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", busy, 0);

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      chunk_q.delete();
      for (int c = 0; c < tbl[t].nc; c++) begin
        for (int i = 0; i < ARRAY_SIZE; i++)
          ch[i] = INPUT_BW'(tbl[t].ramp ? i : tbl[t].base + c * tbl[t].cstep);
        chunk_q.push_back(ch);
      end
      run_job(tbl[t].nc, tbl[t].exp_res, tbl[t].vmode, tbl[t].vpat,
              tbl[t].hold, tbl[t].glitch);
    end

    // Reset mid-job: accept 1 of 3 chunks, then assert reset between edges.
    start = 1'b1;
    num_chunks = CNT_BW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < ARRAY_SIZE; i++) ch[i] = INPUT_BW'(3);
    operands = ch;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midjob_busy", busy, 1);
    chk("midjob_partial", result, 24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_result", result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_result_after_reset", out_valid, 0);
    chk("idle_after_midjob_reset", busy, 0);
    chunk_q.delete();
    for (int i = 0; i < ARRAY_SIZE; i++) ch[i] = INPUT_BW'(5);
    chunk_q.push_back(ch);
    run_job(1, 40, 0, 16'h0000, 0, 1'b0);

    // Random jobs against the lane-sum model.
    for (int r = 0; r < 8; r++) begin
      nc = int'($urandom_range(1, 6));
      chunk_q.delete();
      for (int c = 0; c < nc; c++) begin
        for (int i = 0; i < ARRAY_SIZE; i++) ch[i] = INPUT_BW'($urandom);
        chunk_q.push_back(ch);
      end
      expv = model_sum();
      run_job(nc, expv, 2, 16'h0000, int'($urandom_range(0, 3)), 1'(r[0]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
